// File: rtl/quant_pkg.sv
// Shared types and constants for the two-pass int8 quantization sequencer.
package quant_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SCALE, DRAIN, DONE} qseq_state_t;
  typedef logic [31:0] fp32_t;

  localparam fp32_t      FP32_ONE        = 32'h3F800000;
  localparam fp32_t      FP32_MIN_NORM   = 32'h00800000;
  localparam logic [7:0] FP_EXP_INF      = 8'hFF;
  localparam logic [7:0] SCALE_EXP_SHIFT = 8'd7;

  // amax/128: drop the exponent by 7, saturating to min-normal; zero/denormal amax maps to 1.0
  function automatic fp32_t scale_from_amax(input logic [30:0] amax);
    logic [7:0] e;
    e = amax[30:23];
    if (e == 8'd0)                 return FP32_ONE;
    else if (e <= SCALE_EXP_SHIFT) return FP32_MIN_NORM;
    else                           return {1'b0, e - SCALE_EXP_SHIFT, amax[22:0]};
  endfunction
endpackage

// File: rtl/quant_sequencer_fp2i8.sv
// fp32 -> int8 magnitude quantizer: q = min(trunc(x/scale), 127) for non-negative normal x.
module quant_sequencer_fp2i8
  import quant_pkg::*;
(
  input  fp32_t      x,
  input  fp32_t      scale,
  output logic [7:0] q
);
  logic [7:0]        ex, es;
  logic [23:0]       mx, ms;
  logic signed [9:0] d;
  logic [31:0]       num, quo;

  always_comb begin
    ex  = x[30:23];
    es  = scale[30:23];
    mx  = {1'b1, x[22:0]};
    ms  = {1'b1, scale[22:0]};
    d   = $signed({2'b00, ex}) - $signed({2'b00, es});
    num = '0;
    quo = '0;
    q   = '0;
    // mantissa ratio lies in (0.5, 2), so only d in 0..7 needs a real divide
    if (x[31] || scale[31] || ex == 8'd0 || es == 8'd0) q = 8'd0;
    else if (d >= 10'sd8)                               q = 8'd127;
    else if (d < 10'sd0)                                q = 8'd0;
    else begin
      num = {8'b0, mx} << d[2:0];
      quo = num / {8'b0, ms};
      q   = (quo > 32'd127) ? 8'd127 : quo[7:0];
    end
  end
endmodule

// File: rtl/quant_sequencer.sv
// Two-pass per-tensor int8 quantization controller: buffer + amax, derive scale, replay through quantizer.
module quant_sequencer
  import quant_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic [31:0]      scale_out,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int              AW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  qseq_state_t      state, nstate;
  fp32_t            mem [DEPTH];
  logic [CNT_W-1:0] n, n_in, wr_ptr, rd_ptr;
  logic [30:0]      amax;
  fp32_t            wd, rd_word;
  logic [7:0]       q;
  logic             in_fire, out_load;

  assign n_in     = (len > DEPTH_C) ? DEPTH_C : len;
  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign in_fire  = in_valid && in_ready;
  assign out_load = !out_valid || out_ready;
  // Inf/NaN words are zeroed before they can reach amax or the buffer
  assign wd       = (in_data[30:23] == FP_EXP_INF) ? 32'h0 : in_data;
  assign rd_word  = mem[rd_ptr[AW-1:0]];

  quant_sequencer_fp2i8 u_fp2i8 (
    .x     ({1'b0, rd_word[30:0]}),
    .scale (scale_out),
    .q     (q)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = (n_in == '0) ? DONE : LOAD;
      LOAD:    if (in_fire && wr_ptr == n - CNT_W'(1)) nstate = SCALE;
      SCALE:   nstate = DRAIN;
      DRAIN:   if (out_valid && out_ready && out_last) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && in_fire) mem[wr_ptr[AW-1:0]] <= wd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n         <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      amax      <= '0;
      err       <= 1'b0;
      scale_out <= FP32_ONE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          n      <= n_in;
          wr_ptr <= '0;
          rd_ptr <= '0;
          amax   <= '0;
          err    <= 1'b0;
        end
        LOAD: if (in_fire) begin
          wr_ptr <= wr_ptr + CNT_W'(1);
          if (in_data[30:23] == FP_EXP_INF) err <= 1'b1;
          if (wd[30:0] > amax) amax <= wd[30:0];
        end
        SCALE: scale_out <= scale_from_amax(amax);
        DRAIN: if (out_load) begin
          if (rd_ptr != n) begin
            out_valid <= 1'b1;
            out_data  <= rd_word[31] ? (8'd0 - q) : q;
            out_last  <= (rd_ptr == n - CNT_W'(1));
            rd_ptr    <= rd_ptr + CNT_W'(1);
          end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_quant_sequencer.sv
// Directed bench for quant_sequencer: hand-computed scale/int8 vectors, backpressure, boundaries, reset.
module tb_quant_sequencer;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic             clk, rst, start, in_valid, in_ready, out_valid, out_ready;
  logic [CNT_W-1:0] len;
  logic [31:0]      in_data, scale_out;
  logic [7:0]       out_data;
  logic             out_last, busy, done, err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] in_vec  [32];
  logic [7:0]  exp_vec [32];

  quant_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .scale_out(scale_out), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic run_job(input string nm, input int len_v, input int nin, input int nexp,
                         input logic [31:0] exp_scale, input logic exp_err, input int stall_idx);
    int   k, cyc, stalls;
    logic got_last;
    start = 1'b1; len = CNT_W'(len_v);
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < nin; i++) begin
      in_valid = 1'b1; in_data = in_vec[i];
      chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk({nm, "_in_ready_full"}, 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk({nm, "_scale"}, scale_out, exp_scale);
    chk({nm, "_first_valid_late"}, 32'(out_valid), 32'd0);
    k = 0; cyc = 0; stalls = 0; got_last = 1'b0;
    while (!got_last && cyc < 200) begin
      out_ready = 1'b1;
      if (out_valid && k == stall_idx && stalls < 3) begin
        out_ready = 1'b0;
        stalls++;
        chk({nm, "_hold_data"}, 32'(out_data), 32'(exp_vec[k]));
      end
      if (out_valid && out_ready) begin
        chk({nm, "_data"}, 32'(out_data), 32'(exp_vec[k]));
        chk({nm, "_last"}, 32'(out_last), 32'(k == nexp - 1));
        got_last = out_last;
        k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b1;
    chk({nm, "_count"}, 32'(k), 32'(nexp));
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_done_no_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_err"}, 32'(err), 32'(exp_err));
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, 32'(done), 32'd0);
    chk({nm, "_idle"}, 32'(busy), 32'd0);
    chk({nm, "_err_persist"}, 32'(err), 32'(exp_err));
    chk({nm, "_scale_persist"}, scale_out, exp_scale);
  endtask

  task automatic set_test1();
    in_vec[0] = 32'h3F800000; in_vec[1] = 32'hC0000000;
    in_vec[2] = 32'h3F000000; in_vec[3] = 32'h40800000;
    exp_vec[0] = 8'h20; exp_vec[1] = 8'hC0; exp_vec[2] = 8'h10; exp_vec[3] = 8'h7F;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_scale", scale_out, 32'h3F800000);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // in_valid while idle must not be taken
    in_valid = 1'b1; in_data = 32'h7F000000;
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    set_test1();
    run_job("t1", 4, 4, 4, 32'h3D000000, 1'b0, -1);

    set_test1();
    run_job("t2", 4, 4, 4, 32'h3D000000, 1'b0, 1);

    in_vec[0] = 32'h00000000; in_vec[1] = 32'h80000000;
    exp_vec[0] = 8'h00; exp_vec[1] = 8'h00;
    run_job("t3", 2, 2, 2, 32'h3F800000, 1'b0, -1);

    in_vec[0] = 32'h7FC00000; in_vec[1] = 32'h40000000; in_vec[2] = 32'hC0800000;
    exp_vec[0] = 8'h00; exp_vec[1] = 8'h40; exp_vec[2] = 8'h81;
    run_job("t4", 3, 3, 3, 32'h3D000000, 1'b1, -1);

    // len=0: straight to DONE with no output
    start = 1'b1; len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5z_done", 32'(done), 32'd1);
    chk("t5z_no_valid", 32'(out_valid), 32'd0);
    chk("t5z_err_cleared", 32'(err), 32'd0);
    @(posedge clk); #1;
    chk("t5z_done_pulse", 32'(done), 32'd0);
    chk("t5z_idle", 32'(busy), 32'd0);

    // len=DEPTH+5 clamps to DEPTH; 1.0 everywhere except a 4.0 at the end -> scale 1/32
    for (int i = 0; i < DEPTH; i++) begin
      in_vec[i]  = (i == DEPTH - 1) ? 32'h40800000 : 32'h3F800000;
      exp_vec[i] = (i == DEPTH - 1) ? 8'h7F : 8'h20;
    end
    run_job("t5f", DEPTH + 5, DEPTH, DEPTH, 32'h3D000000, 1'b0, -1);

    // reset in the middle of DRAIN
    set_test1();
    start = 1'b1; len = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = in_vec[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("t6_mid_drain_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_scale", scale_out, 32'h3F800000);
    rst = 1'b0;
    @(posedge clk); #1;
    run_job("t6", 4, 4, 4, 32'h3D000000, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
